// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the decimal (BCD) arithmetic datapath.
//   bcd_digit_t : one packed BCD digit (4 bits)
//   BCD_MAX     : largest legal digit value (9)
//   BCD_BASE    : decimal radix (10), used for borrow correction
//   state_t     : serial subtractor control states
//   is_bcd()    : returns 1 when a 4-bit digit is a legal BCD digit
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_BASE = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_bcd(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtract with borrow: d = a - b - bin,
// corrected by +10 when the raw result is negative (bout = 1).
// Counterpart of the BCD digit adder; shared by the SUB and FIX passes.
// Ports:
//   a_i    : minuend digit (BCD)
//   b_i    : subtrahend digit (BCD)
//   bin_i  : borrow in
//   d_o    : difference digit (BCD)
//   bout_o : borrow out
// -----------------------------------------------------------------------------
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       bin_i,
    output bcd_digit_t d_o,
    output logic       bout_o
);

    // 5-bit signed-width difference; bit 4 is the sign.
    logic [4:0] t;

    always_comb begin
        t      = {1'b0, a_i} - {1'b0, b_i} - {4'b0000, bin_i};
        bout_o = t[4];
        // t in -10..-1 wraps to 6..15 in 4 bits; +10 mod 16 lands on 0..9.
        d_o    = t[4] ? (t[3:0] + BCD_BASE) : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// -----------------------------------------------------------------------------
// bcd_serial_subtractor
// Digit-serial multi-digit BCD subtractor computing A - B, one digit per
// clock, least-significant digit first, with a start/ready/done handshake.
// Operands containing a digit > 9 are rejected with invalid=1.
//
// Optional build macro: BCD_SUB_SIGNED_MAG_EN
//   undefined : diff is the ten's complement of A-B modulo 10^DIGITS
//   defined   : negative results get a FIX pass (0 - diff) so diff holds
//               |A-B| and borrow acts as the sign
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request, accepted only while ready=1
//   a, b    : packed BCD minuend / subtrahend, digit 0 in bits [3:0]
//   ready   : block can accept start (IDLE or DONE)
//   done    : one-cycle pulse, result valid
//   diff    : packed BCD result
//   borrow  : result negative (A < B)
//   invalid : an operand digit was greater than 9
// -----------------------------------------------------------------------------
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  borrow,
    output logic                  invalid
);

    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, a_d;
    logic [4*DIGITS-1:0]   b_q, b_d;
    logic [4*DIGITS-1:0]   diff_q, diff_d;
    logic                  borrow_q, borrow_d;
    logic                  invalid_q, invalid_d;
    logic                  br_q, br_d;
    logic [IDXW-1:0]       idx_q, idx_d;

    logic [IDXW+1:0]       base;
    logic                  last_digit;
    logic                  ops_valid;
    bcd_digit_t            sub_a, sub_b, sub_d;
    logic                  sub_bout;

    assign base       = {idx_q, 2'b00};
    assign last_digit = (idx_q == IDXW'(DIGITS - 1));

    // Validity of the operands presented on the inputs at start time.
    always_comb begin
        ops_valid = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
                ops_valid = 1'b0;
            end
        end
    end

    // Digit operand select: SUB uses a_i - b_i, FIX uses 0 - diff_i.
    always_comb begin
        sub_a = a_q[base +: 4];
        sub_b = b_q[base +: 4];
`ifdef BCD_SUB_SIGNED_MAG_EN
        if (state_q == FIX) begin
            sub_a = '0;
            sub_b = diff_q[base +: 4];
        end
`endif
    end

    bcd_digit_sub u_digit_sub (
        .a_i    (sub_a),
        .b_i    (sub_b),
        .bin_i  (br_q),
        .d_o    (sub_d),
        .bout_o (sub_bout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        invalid_d = invalid_q;
        br_d      = br_q;
        idx_d     = idx_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    diff_d    = '0;
                    borrow_d  = 1'b0;
                    invalid_d = 1'b0;
                    br_d      = 1'b0;
                    idx_d     = '0;
                    if (ops_valid) begin
                        state_d = SUB;
                    end else begin
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            SUB: begin
                diff_d[base +: 4] = sub_d;
                br_d              = sub_bout;
                idx_d             = idx_q + IDXW'(1);
                if (last_digit) begin
                    borrow_d = sub_bout;
                    br_d     = 1'b0;
                    idx_d    = '0;
`ifdef BCD_SUB_SIGNED_MAG_EN
                    state_d  = sub_bout ? FIX : DONE;
`else
                    state_d  = DONE;
`endif
                end
            end

`ifdef BCD_SUB_SIGNED_MAG_EN
            // borrow_q already holds the sign; only diff is rewritten here.
            FIX: begin
                diff_d[base +: 4] = sub_d;
                br_d              = sub_bout;
                idx_d             = idx_q + IDXW'(1);
                if (last_digit) begin
                    br_d    = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            invalid_q <= 1'b0;
            br_q      <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            invalid_q <= invalid_d;
            br_q      <= br_d;
            idx_q     <= idx_d;
        end
    end

    assign ready   = (state_q == IDLE) || (state_q == DONE);
    assign done    = (state_q == DONE);
    assign diff    = diff_q;
    assign borrow  = borrow_q;
    assign invalid = invalid_q;

endmodule
